// File: rtl/imem_loader_pkg.sv
// imem_loader shared constants: default geometry, word size, FSM states.
package imem_loader_pkg;

  localparam int DEPTH_DEF      = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHK   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction memory loader.
interface imem_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Shifts stream bytes into a big-endian word; strobes on the final byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word_next,
  output logic        word_done
);

  // Only the three earlier bytes need storage; the last one is live.
  logic [23:0] acc;
  logic [1:0]  cnt;

  assign word_next = {acc, data};
  assign word_done = shift && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (shift) begin
      acc <= word_next[23:0];
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory and holds the CPU until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      stream,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  logic [2:0]    state;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] n;
  logic [ADDR_W:0] idx_inc;
  logic          xfer;
  logic          hdr_ok;
  logic          last_state_hit;
  logic [31:0]   word_next;
  logic          word_done;
  logic [2:0]    after_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign after_last = S_CHK;
`else
  assign after_last = S_DONE;
`endif

  assign stream.in_ready = (state == S_HDR)
                        || (state == S_DATA)
                        || (state == S_CHK);

  assign xfer     = stream.in_valid && stream.in_ready;
  assign hdr_ok   = (stream.in_data != 8'd0)
                 && (32'(stream.in_data) <= DEPTH);
  // Index is one bit wider than the address so N == DEPTH compares exactly.
  assign idx_inc  = idx + (ADDR_W + 1)'(1);
  assign last_state_hit = (idx_inc == n);

  assign cpu_hold = (state != S_DONE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);

  imem_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (xfer && (state == S_HDR)),
    .shift     (xfer && (state == S_DATA)),
    .data      (stream.in_data),
    .word_next (word_next),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_HDR;
      idx       <= '0;
      n         <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_HDR: begin
          if (xfer) begin
            if (hdr_ok) begin
              n     <= stream.in_data[ADDR_W:0];
              idx   <= '0;
              state <= S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum  <= '0;
`endif
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (xfer) csum <= csum ^ stream.in_data;
`endif
          // Write port is loaded here so it is valid during WRITE.
          if (word_done) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx[ADDR_W-1:0];
            mem_wdata <= word_next;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          idx   <= idx_inc;
          state <= last_state_hit ? after_last : S_DATA;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            state <= (stream.in_data == csum) ? S_DONE : S_ERR;
          end
        end
`endif
        S_DONE, S_ERR: begin
          if (start) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads, errors, stalls, reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int c0 = 0;
  int at = 0;

  wr_t         sb[$];
  logic [31:0] prog[$];
  logic [7:0]  bx;

  imem_loader_if bus ();

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stream    (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      chk("in_ready_in_write", 32'(bus.in_ready), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected none",
                 mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for byte %h", b);
    end
    last_cyc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flag(input bit want_done, output int when);
    int t;
    t = 0;
    when = -1;
    while (t < 20) begin
      @(negedge clk);
      if (want_done ? done : error) begin
        when = cyc;
        break;
      end
      t++;
    end
    checks++;
    if (when < 0) begin
      errors++;
      $display("FAIL wait_%s: got no rise expected rise within 20 cycles",
               want_done ? "done" : "error");
    end
  endtask

  task automatic load(input bit gap);
    logic [7:0] b;
    bx = 8'd0;
    send(8'(prog.size()));
    c0 = last_cyc;
    foreach (prog[i]) begin
      sb.push_back('{a: 5'(i), d: prog[i]});
      for (int k = 0; k < 4; k++) begin
        b = prog[i][31-8*k -: 8];
        bx ^= b;
        send(b);
        if (gap) idle();
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    chk("start_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic finish_ok(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(bx);
`endif
    wait_flag(1'b1, at);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_all_written"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    prog = {32'h20010005, 32'h00221820};
    load(1'b0);
    finish_ok("two_words");

    pulse_start();
    send(8'h00);
    wait_flag(1'b0, at);
    chk("n0_hold", 32'(cpu_hold), 32'd1);
    chk("n0_done", 32'(done), 32'd0);
    pulse_start();
    send(8'h21);
    wait_flag(1'b0, at);
    chk("n33_hold", 32'(cpu_hold), 32'd1);

    pulse_start();
    prog.delete();
    for (int i = 0; i < 32; i++) prog.push_back(32'(i));
    load(1'b0);
    finish_ok("full");
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("full_done_cycle", 32'(at), 32'(c0 + 1 + 32 * 5 + 1));
`else
    chk("full_done_cycle", 32'(at), 32'(c0 + 1 + 32 * 5));
`endif

    pulse_start();
    prog = {32'hDEADBEEF, 32'h0BADF00D};
    load(1'b1);
    finish_ok("backpressure");

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    prog = {32'hAABBCCDD};
    load(1'b0);
    send(bx ^ 8'hFF);
    wait_flag(1'b0, at);
    chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
    pulse_start();
    load(1'b0);
    finish_ok("csum_good");
`endif

    pulse_start();
    send(8'h01);
    send(8'h99);
    send(8'h88);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midrst");
    prog = {32'h11223344};
    load(1'b0);
    finish_ok("after_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
